// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider (signed/unsigned) with annul and synchronous reset.
// Optional divide-by-zero flag output dbz_o is enabled by defining DIV_BYZERO_FLAG_EN.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
`ifdef DIV_BYZERO_FLAG_EN
   output logic        dbz_o,
`endif
   output logic        stallreq_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [5:0]  cnt_r, cnt_s;
   logic [64:0] work_r, work_s;
   logic [31:0] divisor_r, divisor_s;
   logic        neg_q_r, neg_q_s;
   logic        neg_rem_r, neg_rem_s;
   logic [63:0] result_s;
   logic        ready_s;
   logic [32:0] diff_s;
`ifdef DIV_BYZERO_FLAG_EN
   logic        byzero_r, byzero_s;
   logic        dbz_s;
`endif

   function automatic logic [31:0] magnitude(input logic neg, input logic [31:0] v);
      return neg ? (32'd0 - v) : v;
   endfunction

   // Trial subtraction of the divisor from the upper partial remainder.
   assign diff_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};

   assign stallreq_o = start_i & ~ready_o & ~annul_i;

   // Next-state, datapath and registered-output next values.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      work_s    = work_r;
      divisor_s = divisor_r;
      neg_q_s   = neg_q_r;
      neg_rem_s = neg_rem_r;
      result_s  = result_o;
      ready_s   = ready_o;
`ifdef DIV_BYZERO_FLAG_EN
      byzero_s  = byzero_r;
      dbz_s     = dbz_o;
`endif
      case (state_r)
         IDLE: begin
            ready_s  = 1'b0;
            result_s = 64'd0;
`ifdef DIV_BYZERO_FLAG_EN
            dbz_s    = 1'b0;
`endif
            if (start_i && !annul_i) begin
               cnt_s     = 6'd0;
               divisor_s = magnitude(signed_div_i & opdata2_i[31], opdata2_i);
               neg_q_s   = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
               neg_rem_s = signed_div_i & opdata1_i[31];
               work_s    = {32'd0, magnitude(signed_div_i & opdata1_i[31], opdata1_i), 1'b0};
`ifdef DIV_BYZERO_FLAG_EN
               byzero_s  = (opdata2_i == 32'd0);
`endif
               if (opdata2_i == 32'd0) begin
                  state_s = BYZERO;
               end else begin
                  state_s = ON;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BYZERO: begin
            if (annul_i) begin
               state_s = IDLE;
            end else begin
               state_s = END;
               work_s  = 65'd0;
            end
         end
         ON: begin
            if (annul_i) begin
               state_s  = IDLE;
               cnt_s    = 6'd0;
               ready_s  = 1'b0;
               result_s = 64'd0;
            end else if (cnt_r != 6'd32) begin
               cnt_s = cnt_r + 6'd1;
               if (diff_s[32]) begin
                  work_s = {work_r[63:0], 1'b0};
               end else begin
                  work_s = {diff_s[31:0], work_r[31:0], 1'b1};
               end
            end else begin
               // Quotient sits in [31:0], remainder in [64:33]; apply signs here.
               work_s[31:0]  = magnitude(neg_q_r, work_r[31:0]);
               work_s[64:33] = magnitude(neg_rem_r, work_r[64:33]);
               cnt_s         = 6'd0;
               state_s       = END;
            end
         end
         END: begin
            if (annul_i || !start_i) begin
               state_s  = IDLE;
               ready_s  = 1'b0;
               result_s = 64'd0;
`ifdef DIV_BYZERO_FLAG_EN
               dbz_s    = 1'b0;
`endif
            end else begin
               ready_s  = 1'b1;
               result_s = {work_r[64:33], work_r[31:0]};
`ifdef DIV_BYZERO_FLAG_EN
               dbz_s    = byzero_r;
`endif
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 6'd0;
         work_r    <= 65'd0;
         divisor_r <= 32'd0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         result_o  <= 64'd0;
         ready_o   <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
         byzero_r  <= 1'b0;
         dbz_o     <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         work_r    <= work_s;
         divisor_r <= divisor_s;
         neg_q_r   <= neg_q_s;
         neg_rem_r <= neg_rem_s;
         result_o  <= result_s;
         ready_o   <= ready_s;
`ifdef DIV_BYZERO_FLAG_EN
         byzero_r  <= byzero_s;
         dbz_o     <= dbz_s;
`endif
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: randomized and directed divides checked against
// plain-arithmetic quotient/remainder and the required latency.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic        start_i, annul_i;
   logic [63:0] result_o;
   logic        ready_o, stallreq_o;
`ifdef DIV_BYZERO_FLAG_EN
   logic        dbz_o;
`endif

   div_unit dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .start_i(start_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o),
`ifdef DIV_BYZERO_FLAG_EN
      .dbz_o(dbz_o),
`endif
      .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      int          sample_edge;
      int          lat;
      logic        dbz;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer division, truncating toward zero.
   function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         e.res = 64'd0; e.lat = 2; e.dbz = 1'b1;
      end else begin
         sa = sgn ? longint'($signed(a)) : longint'(a);
         sb = sgn ? longint'($signed(b)) : longint'(b);
         q  = sa / sb;
         r  = sa % sb;
         e.res = {r[31:0], q[31:0]};
         e.lat = 34; e.dbz = 1'b0;
      end
      e.sample_edge = 0;
      return e;
   endfunction

   // Monitor: pops the scoreboard on every rising ready_o.
   always @(negedge clk) begin
      if (!rst && ready_o && !prev_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ready", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", result_o, e.res);
            chk("latency", 64'(cyc - e.sample_edge), 64'(e.lat));
`ifdef DIV_BYZERO_FLAG_EN
            chk("dbz", 64'(dbz_o), 64'(e.dbz));
`endif
         end
      end
      prev_ready <= ready_o;
   end

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      int          n;
      logic [63:0] held;
      @(negedge clk);
      signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
      e = model(sgn, a, b);
      e.sample_edge = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
      n = 0;
      while (!ready_o && n < 60) begin
         chk("stallreq_busy", 64'(stallreq_o), 64'd1);
         @(negedge clk);
         n++;
      end
      if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
      held = result_o;
      chk("stallreq_done", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      chk("ready_hold", 64'(ready_o), 64'd1);
      chk("result_hold", result_o, held);
      start_i = 1'b0;
      @(negedge clk);
      chk("ready_clear", 64'(ready_o), 64'd0);
      chk("result_clear", result_o, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
      chk("dbz_clear", 64'(dbz_o), 64'd0);
`endif
   endtask

   initial begin
      logic [31:0] a, b;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_stall", 64'(stallreq_o), 64'd0);
      rst = 1'b0;

      do_div(1'b0, 32'd100, 32'd7);
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div(1'b0, 32'd12345, 32'd0);
      do_div(1'b1, 32'hFFFF_FF00, 32'd0);
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE);

      // Annul mid-division: no ready pulse, then a fresh divide completes.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (11) @(negedge clk);
      annul_i = 1'b1;
      #1 chk("stallreq_annul", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_result", result_o, 64'd0);
      annul_i = 1'b0; start_i = 1'b0;
      repeat (40) @(negedge clk);
      do_div(1'b0, 32'd1000, 32'd3);

      // Reset mid-division while start and annul stay high.
      @(negedge clk);
      signed_div_i = 1'b1; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'd17; start_i = 1'b1;
      repeat (21) @(negedge clk);
      rst = 1'b1; annul_i = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         do_div(1'($urandom_range(0, 1)), a, b);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide port: clk  input  1  rising-edge clock.
REQ-002 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned.
REQ-004 SHALL provide port: opdata1_i  input  32  dividend.
REQ-005 SHALL provide port: opdata2_i  input  32  divisor.
REQ-006 SHALL provide port: start_i  input  1  divide request from the EX stage; held high until result is consumed.
REQ-007 SHALL provide port: annul_i  input  1  cancel the in-flight divide (branch-delay flush).
REQ-008 SHALL provide port: result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL provide port: ready_o  output  1  result_o valid.
REQ-010 SHALL provide port: stallreq_o  output  1  stall request toward the pipeline stall controller.

Function
REQ-011 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-012 IDLE: start_i=1 and annul_i=0 at an edge SHALL latch operands and signed_div_i; go to BYZERO if opdata2_i==0, else to ON with iteration count 0.
REQ-013 Signed mode SHALL convert negative operands to magnitude before iterating; unsigned mode SHALL use operands unchanged.
REQ-014 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register, 32 steps total.
REQ-015 After step 32, quotient SHALL be negated if signed and operand signs differ, remainder SHALL be negated if signed and dividend negative; state goes to END.
REQ-016 BYZERO SHALL go to END on the next edge with result 64'h0.
REQ-017 END SHALL drive ready_o=1 and hold result_o stable; when start_i=0 at an edge, go to IDLE with ready_o=0 and result_o=0.
REQ-018 Latency: ready_o SHALL rise exactly 34 edges after the edge sampling start_i (non-zero divisor), 2 edges for divisor zero.
REQ-019 annul_i=1 in ON or BYZERO SHALL return to IDLE on the next edge, no ready_o pulse, result_o=0; annul_i has priority over start_i.
REQ-020 annul_i=1 in END SHALL return to IDLE on the next edge.
REQ-021 stallreq_o SHALL be combinational: start_i & ~ready_o & ~annul_i.
REQ-022 Operand changes on the inputs after latching SHALL NOT affect the in-flight result.
REQ-023 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (wrap, no exception).
REQ-024 ready_o and result_o SHALL be registered outputs.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, iteration count 0, result_o=0, ready_o=0, regardless of state, including mid-division.
REQ-026 rst SHALL dominate start_i and annul_i.

Configuration
REQ-027 Macro DIV_BYZERO_FLAG_EN defined: SHALL add output dbz_o (1 bit), registered, asserted with ready_o when the latched divisor was zero, cleared with ready_o and by reset.
REQ-028 Macro DIV_BYZERO_FLAG_EN undefined: dbz_o SHALL be absent; all other behaviour identical.

Verification
REQ-029 Unsigned 100 / 7, start held -> ready_o high at edge 34, result_o = {32'd2, 32'd14}; start_i low -> ready_o 0 next edge.
REQ-030 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
REQ-031 Divisor 0 -> ready_o at edge 2, result_o 0; with DIV_BYZERO_FLAG_EN dbz_o=1 at the same edge.
REQ-032 annul_i pulsed at step 10 -> IDLE next edge, ready_o never asserted, stallreq_o 0 during annul; new start then completes normally in 34 edges.
REQ-033 rst asserted at step 20 -> IDLE, ready_o=0, result_o=0 next edge; stallreq_o = start_i throughout the divide until ready_o.
